pipe_ctrl: RTL and testbench

Central pipeline sequencing controller for the five-stage in-order core. Each cycle it decides hold, flush and bubble controls for every inter-stage register (IF/DC, DC/EX, EX/MEM, MEM/WB) and selects the fetch redirect PC. It also runs the multi-cycle fence.i sequence: drain, I-cache flush, then refetch. It feeds the `hold`, `flush_if` and `cancel_instr` inputs of the stage registers.

---
 rtl/pipe_ctrl_if.sv | 41 ++++
 rtl/pipe_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_ctrl.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the pipeline stages and pipe_ctrl: stall/redirect requests in,
// stage-register hold/flush/bubble controls and fetch redirect out.
interface pipe_ctrl_if #(parameter int ADDR_W = 64);
    logic              ifu_stall;
    logic              load_use;
    logic              mdu_busy;
    logic              lsu_busy;
    logic              br_redirect;
    logic [ADDR_W-1:0] br_target;
    logic              trap_redirect;
    logic [ADDR_W-1:0] trap_target;
    logic              fence_i_dc;
    logic [ADDR_W-1:0] fence_pc;
    logic              sb_empty;

    logic              hold_if, hold_dc, hold_ex, hold_mem;
    logic              flush_if, flush_dc, flush_ex, flush_mem;
    logic              cancel_if;
    logic              bubble_ex;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              icache_flush;
    logic              br_accept;
    logic [31:0]       stall_cnt;

    modport master (
        output ifu_stall, load_use, mdu_busy, lsu_busy, br_redirect, br_target,
               trap_redirect, trap_target, fence_i_dc, fence_pc, sb_empty,
        input  hold_if, hold_dc, hold_ex, hold_mem, flush_if, flush_dc, flush_ex,
               flush_mem, cancel_if, bubble_ex, redirect_valid, redirect_pc,
               icache_flush, br_accept, stall_cnt
    );

    modport slave (
        input  ifu_stall, load_use, mdu_busy, lsu_busy, br_redirect, br_target,
               trap_redirect, trap_target, fence_i_dc, fence_pc, sb_empty,
        output hold_if, hold_dc, hold_ex, hold_mem, flush_if, flush_dc, flush_ex,
               flush_mem, cancel_if, bubble_ex, redirect_valid, redirect_pc,
               icache_flush, br_accept, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage hold/flush/bubble controls, fetch redirect
// selection (trap > branch > fence.i refetch) and the fence.i drain/flush/refetch sequence.
module pipe_ctrl #(
    parameter int ADDR_W      = 64,
    parameter int ICFLUSH_CYC = 4
) (
    input logic        clk,
    input logic        rstn,
    pipe_ctrl_if.slave bus
);
    localparam int FL_W = $clog2(ICFLUSH_CYC + 1);

    typedef enum logic [1:0] {RUN, DRAIN, ICFLUSH, REFETCH} state_t;

    state_t            state_q, state_d;
    logic [FL_W-1:0]   fl_cnt_q, fl_cnt_d;
    logic [ADDR_W-1:0] refetch_pc_q, refetch_pc_d;
    logic [31:0]       stall_cnt_q;
    logic              hold_mem_c, hold_ex_c, hold_dc_c;
    logic              br_go, fence_go;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= RUN;
            fl_cnt_q     <= '0;
            refetch_pc_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            fl_cnt_q     <= fl_cnt_d;
            refetch_pc_q <= refetch_pc_d;
            if (bus.hold_if)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        fl_cnt_d     = fl_cnt_q;
        refetch_pc_d = refetch_pc_q;

        hold_mem_c = bus.lsu_busy;
        hold_ex_c  = hold_mem_c | bus.mdu_busy;
        hold_dc_c  = hold_ex_c | bus.load_use | (state_q != RUN);

        bus.hold_mem       = hold_mem_c;
        bus.hold_ex        = hold_ex_c;
        bus.hold_dc        = hold_dc_c;
        bus.hold_if        = hold_dc_c;
        bus.bubble_ex      = bus.load_use & ~hold_ex_c;
        bus.cancel_if      = (bus.ifu_stall & ~hold_dc_c) | (state_q == DRAIN);
        bus.flush_if       = 1'b0;
        bus.flush_dc       = 1'b0;
        bus.flush_ex       = 1'b0;
        bus.flush_mem      = 1'b0;
        bus.br_accept      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.icache_flush   = (state_q == ICFLUSH);
        bus.stall_cnt      = stall_cnt_q;

        br_go    = (state_q == RUN) & bus.br_redirect & ~hold_ex_c & ~bus.trap_redirect;
        fence_go = (state_q == RUN) & bus.fence_i_dc & ~hold_dc_c & ~bus.trap_redirect & ~br_go;

        case (state_q)
            RUN: begin
                if (br_go) begin
                    // A redirect must not be frozen behind a load-use hold in IF/DC.
                    bus.br_accept      = 1'b1;
                    bus.flush_if       = 1'b1;
                    bus.flush_dc       = 1'b1;
                    bus.hold_if        = 1'b0;
                    bus.hold_dc        = 1'b0;
                    bus.redirect_valid = 1'b1;
                    bus.redirect_pc    = bus.br_target;
                end else if (fence_go) begin
                    bus.flush_if = 1'b1;
                    refetch_pc_d = bus.fence_pc + ADDR_W'(4);
                    state_d      = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.sb_empty & ~bus.lsu_busy & ~bus.mdu_busy) begin
                    fl_cnt_d = FL_W'(ICFLUSH_CYC - 1);
                    state_d  = ICFLUSH;
                end
            end
            ICFLUSH: begin
                if (fl_cnt_q == '0)
                    state_d = REFETCH;
                else
                    fl_cnt_d = fl_cnt_q - FL_W'(1);
            end
            REFETCH: begin
                bus.flush_if       = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = refetch_pc_q;
                state_d            = RUN;
            end
            default: state_d = RUN;
        endcase

        if (bus.trap_redirect) begin
            bus.flush_if       = 1'b1;
            bus.flush_dc       = 1'b1;
            bus.flush_ex       = 1'b1;
            bus.flush_mem      = 1'b1;
            bus.hold_if        = 1'b0;
            bus.hold_dc        = 1'b0;
            bus.hold_ex        = 1'b0;
            bus.hold_mem       = 1'b0;
            bus.br_accept      = 1'b0;
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = bus.trap_target;
            state_d            = RUN;
            fl_cnt_d           = '0;
        end

        // Reset presents every stage register with a cancelled slot and nothing else.
        if (!rstn) begin
            bus.flush_if       = 1'b1;
            bus.flush_dc       = 1'b1;
            bus.flush_ex       = 1'b1;
            bus.flush_mem      = 1'b1;
            bus.hold_if        = 1'b0;
            bus.hold_dc        = 1'b0;
            bus.hold_ex        = 1'b0;
            bus.hold_mem       = 1'b0;
            bus.cancel_if      = 1'b0;
            bus.bubble_ex      = 1'b0;
            bus.br_accept      = 1'b0;
            bus.redirect_valid = 1'b0;
            bus.redirect_pc    = '0;
            bus.icache_flush   = 1'b0;
            bus.stall_cnt      = '0;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic compared
// against a behavioural model; a second instance covers the single-cycle I-cache flush.
module tb_pipe_ctrl;
    localparam int ADDR_W = 64;
    localparam int ICF    = 4;
    localparam logic [12:0] RESET_V = 13'h1E0;

    logic clk;
    logic rstn;
    int   checks = 0;
    int   fails  = 0;

    pipe_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
    pipe_ctrl_if #(.ADDR_W(ADDR_W)) bus1 ();

    pipe_ctrl #(.ADDR_W(ADDR_W), .ICFLUSH_CYC(ICF)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave));
    pipe_ctrl #(.ADDR_W(ADDR_W), .ICFLUSH_CYC(1))   dut1 (.clk(clk), .rstn(rstn), .bus(bus1.slave));

    assign bus1.ifu_stall     = bus.ifu_stall;
    assign bus1.load_use      = bus.load_use;
    assign bus1.mdu_busy      = bus.mdu_busy;
    assign bus1.lsu_busy      = bus.lsu_busy;
    assign bus1.br_redirect   = bus.br_redirect;
    assign bus1.br_target     = bus.br_target;
    assign bus1.trap_redirect = bus.trap_redirect;
    assign bus1.trap_target   = bus.trap_target;
    assign bus1.fence_i_dc    = bus.fence_i_dc;
    assign bus1.fence_pc      = bus.fence_pc;
    assign bus1.sb_empty      = bus.sb_empty;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // {hold_if,hold_dc,hold_ex,hold_mem,flush_if,flush_dc,flush_ex,flush_mem,cancel_if,bubble_ex,redirect_valid,icache_flush,br_accept}
    function automatic logic [12:0] obs();
        return {bus.hold_if, bus.hold_dc, bus.hold_ex, bus.hold_mem,
                bus.flush_if, bus.flush_dc, bus.flush_ex, bus.flush_mem,
                bus.cancel_if, bus.bubble_ex, bus.redirect_valid, bus.icache_flush, bus.br_accept};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ifu_stall = 0; bus.load_use = 0; bus.mdu_busy = 0; bus.lsu_busy = 0;
        bus.br_redirect = 0; bus.br_target = '0; bus.trap_redirect = 0; bus.trap_target = '0;
        bus.fence_i_dc = 0; bus.fence_pc = '0; bus.sb_empty = 1;
    endtask

    task automatic do_reset();
        idle();
        rstn = 0;
        next_cycle();
        next_cycle();
        rstn = 1;
    endtask

    task automatic test_reset();
        rstn = 0;
        for (int i = 0; i < 4; i++) begin
            bus.ifu_stall = 1'($urandom); bus.load_use = 1'($urandom); bus.mdu_busy = 1'($urandom);
            bus.lsu_busy = 1'($urandom); bus.br_redirect = 1'($urandom); bus.trap_redirect = 1'($urandom);
            bus.fence_i_dc = 1'($urandom); bus.sb_empty = 1'($urandom);
            bus.br_target = {$urandom, $urandom}; bus.trap_target = {$urandom, $urandom};
            @(negedge clk);
            checks++;
            if (obs() !== RESET_V || bus.redirect_pc !== '0 || bus.stall_cnt !== 32'd0) begin
                fails++;
                $display("[TB] FAIL reset_outputs: got %h pc %h cnt %0d, expected %h pc 0 cnt 0",
                         obs(), bus.redirect_pc, bus.stall_cnt, RESET_V);
            end
            next_cycle();
        end
        idle();
        rstn = 1;
        @(negedge clk);
        checks++;
        if (obs() !== 13'h0 || bus.stall_cnt !== 32'd0 || bus.redirect_pc !== '0) begin
            fails++;
            $display("[TB] FAIL reset_release: got %h cnt %0d pc %h, expected 0000 cnt 0 pc 0",
                     obs(), bus.stall_cnt, bus.redirect_pc);
        end
        next_cycle();
    endtask

    task automatic test_stall();
        do_reset();
        bus.mdu_busy = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 13'h1C00 || bus.stall_cnt !== 32'(i)) begin
                fails++;
                $display("[TB] FAIL mdu_stall[%0d]: got %h cnt %0d, expected 1c00 cnt %0d",
                         i, obs(), bus.stall_cnt, i);
            end
            next_cycle();
        end
        bus.mdu_busy = 0;
        bus.load_use = 1;
        @(negedge clk);
        checks++;
        if (obs() !== 13'h1808 || bus.stall_cnt !== 32'd3) begin
            fails++;
            $display("[TB] FAIL load_use_bubble: got %h cnt %0d, expected 1808 cnt 3", obs(), bus.stall_cnt);
        end
        next_cycle();
        bus.load_use = 0;
        bus.ifu_stall = 1;
        @(negedge clk);
        checks++;
        if (obs() !== 13'h0010 || bus.stall_cnt !== 32'd4) begin
            fails++;
            $display("[TB] FAIL after_stall: got %h cnt %0d, expected 0010 cnt 4", obs(), bus.stall_cnt);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_branch(input logic [ADDR_W-1:0] tgt, input logic use_at_accept);
        do_reset();
        bus.br_redirect = 1;
        bus.br_target = tgt;
        bus.lsu_busy = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.br_accept !== 1'b0 || bus.redirect_valid !== 1'b0 || obs() !== 13'h1E00) begin
                fails++;
                $display("[TB] FAIL branch_blocked[%0d]: got %h, expected 1e00", i, obs());
            end
            next_cycle();
        end
        bus.lsu_busy = 0;
        bus.load_use = use_at_accept;
        @(negedge clk);
        checks++;
        if (obs() !== {8'b0000_1100, 1'b0, use_at_accept, 3'b101} || bus.redirect_pc !== tgt) begin
            fails++;
            $display("[TB] FAIL branch_accept: got %h pc %h, expected %h pc %h",
                     obs(), bus.redirect_pc, {8'b0000_1100, 1'b0, use_at_accept, 3'b101}, tgt);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_fence(input logic [ADDR_W-1:0] pc, input int drain);
        logic [ADDR_W-1:0] exp_pc;
        exp_pc = pc + 64'd4;
        do_reset();
        bus.fence_i_dc = 1;
        bus.fence_pc = pc;
        bus.sb_empty = 0;
        @(negedge clk);
        checks++;
        if (obs() !== 13'h0100) begin
            fails++;
            $display("[TB] FAIL fence_accept: got %h, expected 0100", obs());
        end
        next_cycle();
        bus.fence_i_dc = 0;
        for (int k = 1; k <= drain; k++) begin
            bus.sb_empty = (k == drain);
            @(negedge clk);
            checks++;
            if (obs() !== 13'h1810) begin
                fails++;
                $display("[TB] FAIL fence_drain[%0d]: got %h, expected 1810", k, obs());
            end
            next_cycle();
        end
        bus.sb_empty = 1;
        for (int k = 0; k < ICF; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 13'h1802) begin
                fails++;
                $display("[TB] FAIL fence_icflush[%0d]: got %h, expected 1802", k, obs());
            end
            checks++;
            if (bus1.icache_flush !== (k == 0) || bus1.redirect_valid !== (k == 1) ||
                (k == 1 && bus1.redirect_pc !== exp_pc)) begin
                fails++;
                $display("[TB] FAIL fence_icf1[%0d]: got flush %b rv %b pc %h, expected flush %b rv %b pc %h",
                         k, bus1.icache_flush, bus1.redirect_valid, bus1.redirect_pc, k == 0, k == 1, exp_pc);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (obs() !== 13'h1904 || bus.redirect_pc !== exp_pc) begin
            fails++;
            $display("[TB] FAIL fence_refetch: got %h pc %h, expected 1904 pc %h", obs(), bus.redirect_pc, exp_pc);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (obs() !== 13'h0000 || bus.redirect_pc !== '0) begin
            fails++;
            $display("[TB] FAIL fence_done: got %h pc %h, expected 0000 pc 0", obs(), bus.redirect_pc);
        end
        next_cycle();
    endtask

    task automatic test_trap_icflush();
        do_reset();
        bus.fence_i_dc = 1;
        bus.fence_pc = 64'h8000_0200;
        next_cycle();
        bus.fence_i_dc = 0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.icache_flush !== 1'b1) begin
            fails++;
            $display("[TB] FAIL trap_pre_icflush: got %b, expected 1", bus.icache_flush);
        end
        next_cycle();
        bus.trap_redirect = 1;
        bus.trap_target = 64'h8000_0000;
        @(negedge clk);
        checks++;
        if ({bus.flush_if, bus.flush_dc, bus.flush_ex, bus.flush_mem, bus.hold_if, bus.hold_dc, bus.hold_ex,
             bus.hold_mem, bus.redirect_valid} !== 9'b1111_0000_1 || bus.redirect_pc !== 64'h8000_0000) begin
            fails++;
            $display("[TB] FAIL trap_in_icflush: got %h pc %h, expected flush all, holds 0, pc 80000000",
                     obs(), bus.redirect_pc);
        end
        next_cycle();
        bus.trap_redirect = 0;
        @(negedge clk);
        checks++;
        if (obs() !== 13'h0000) begin
            fails++;
            $display("[TB] FAIL trap_after: got %h, expected 0000", obs());
        end
        next_cycle();
        idle();
    endtask

    task automatic test_trap_branch();
        logic [ADDR_W-1:0] tt, bt;
        tt = {$urandom, $urandom};
        bt = {$urandom, $urandom};
        do_reset();
        bus.trap_redirect = 1; bus.trap_target = tt;
        bus.br_redirect = 1;   bus.br_target = bt;
        @(negedge clk);
        checks++;
        if (obs() !== 13'h01E4 || bus.redirect_pc !== tt) begin
            fails++;
            $display("[TB] FAIL trap_vs_branch: got %h pc %h, expected 01e4 pc %h", obs(), bus.redirect_pc, tt);
        end
        next_cycle();
        bus.trap_redirect = 0;
        @(negedge clk);
        checks++;
        if (obs() !== 13'h0185 || bus.redirect_pc !== bt) begin
            fails++;
            $display("[TB] FAIL branch_after_trap: got %h pc %h, expected 0185 pc %h", obs(), bus.redirect_pc, bt);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_reset_midseq();
        do_reset();
        bus.mdu_busy = 1;
        next_cycle();
        bus.mdu_busy = 0;
        bus.fence_i_dc = 1; bus.fence_pc = 64'h1000; bus.sb_empty = 0;
        next_cycle();
        bus.fence_i_dc = 0;
        @(negedge clk);
        checks++;
        if (obs() !== 13'h1810 || bus.stall_cnt !== 32'd1) begin
            fails++;
            $display("[TB] FAIL drain_entry: got %h cnt %0d, expected 1810 cnt 1", obs(), bus.stall_cnt);
        end
        next_cycle();
        rstn = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== RESET_V || bus.stall_cnt !== 32'd0) begin
                fails++;
                $display("[TB] FAIL reset_in_drain[%0d]: got %h cnt %0d, expected %h cnt 0",
                         i, obs(), bus.stall_cnt, RESET_V);
            end
            next_cycle();
        end
        rstn = 1;
        bus.sb_empty = 1;
        @(negedge clk);
        checks++;
        if (obs() !== 13'h0000 || bus.stall_cnt !== 32'd0 || bus.redirect_pc !== '0) begin
            fails++;
            $display("[TB] FAIL reset_drain_release: got %h cnt %0d, expected 0000 cnt 0", obs(), bus.stall_cnt);
        end
        bus.fence_i_dc = 1;
        next_cycle();
        bus.fence_i_dc = 0;
        next_cycle();
        next_cycle();
        rstn = 0;
        @(negedge clk);
        checks++;
        if (bus.icache_flush !== 1'b0 || obs() !== RESET_V) begin
            fails++;
            $display("[TB] FAIL reset_in_icflush: got %h, expected %h", obs(), RESET_V);
        end
        next_cycle();
        rstn = 1;
        @(negedge clk);
        checks++;
        if (obs() !== 13'h0000) begin
            fails++;
            $display("[TB] FAIL icflush_reset_release: got %h, expected 0000", obs());
        end
        next_cycle();
    endtask

    task automatic test_random(input int n);
        logic              in_drain, refetch_due;
        int                flush_left;
        logic [ADDR_W-1:0] m_refetch, e_pc;
        logic [31:0]       stalls, e_cnt;
        logic [12:0]       e_v;
        logic              busy, h_mem, h_ex, h_dc, acc_br, acc_fence;
        logic              e_hif, e_hdc, e_hex, e_hmem, e_fif, e_fdc, e_fex, e_fmem, e_rv, e_bacc;
        do_reset();
        in_drain = 0; refetch_due = 0; flush_left = 0; m_refetch = '0; stalls = '0;
        for (int i = 0; i < n; i++) begin
            rstn = ($urandom_range(63) != 0);
            bus.ifu_stall = ($urandom_range(2) == 0);
            bus.load_use = ($urandom_range(3) == 0);
            bus.mdu_busy = ($urandom_range(3) == 0);
            bus.lsu_busy = ($urandom_range(3) == 0);
            bus.br_redirect = ($urandom_range(2) == 0);
            bus.trap_redirect = ($urandom_range(15) == 0);
            bus.fence_i_dc = ($urandom_range(2) == 0);
            bus.sb_empty = ($urandom_range(2) != 0);
            bus.br_target = {$urandom, $urandom};
            bus.trap_target = {$urandom, $urandom};
            bus.fence_pc = ($urandom_range(7) == 0) ? ~64'd0 - 64'($urandom_range(7)) : {$urandom, $urandom};

            busy  = in_drain | (flush_left > 0) | refetch_due;
            h_mem = bus.lsu_busy;
            h_ex  = bus.lsu_busy | bus.mdu_busy;
            h_dc  = h_ex | bus.load_use | busy;
            e_hif = h_dc; e_hdc = h_dc; e_hex = h_ex; e_hmem = h_mem;
            e_fif = 0; e_fdc = 0; e_fex = 0; e_fmem = 0; e_rv = 0; e_bacc = 0; e_pc = '0;
            acc_br    = !busy && bus.br_redirect && !h_ex && !bus.trap_redirect;
            acc_fence = !busy && bus.fence_i_dc && !h_dc && !bus.trap_redirect && !acc_br;
            if (acc_br) begin
                e_fif = 1; e_fdc = 1; e_hif = 0; e_hdc = 0; e_rv = 1; e_bacc = 1; e_pc = bus.br_target;
            end
            if (acc_fence) e_fif = 1;
            if (refetch_due) begin
                e_fif = 1; e_rv = 1; e_pc = m_refetch;
            end
            if (bus.trap_redirect) begin
                {e_fif, e_fdc, e_fex, e_fmem} = 4'hF;
                {e_hif, e_hdc, e_hex, e_hmem} = 4'h0;
                e_rv = 1; e_bacc = 0; e_pc = bus.trap_target;
            end
            e_v = {e_hif, e_hdc, e_hex, e_hmem, e_fif, e_fdc, e_fex, e_fmem,
                   (bus.ifu_stall & !h_dc) | in_drain, bus.load_use & !h_ex, e_rv, flush_left > 0, e_bacc};
            e_cnt = stalls;
            if (!rstn) begin
                e_v = RESET_V; e_pc = '0; e_cnt = '0;
            end

            @(negedge clk);
            checks++;
            if (obs() !== e_v || bus.redirect_pc !== e_pc || bus.stall_cnt !== e_cnt) begin
                fails++;
                $display("[TB] FAIL random[%0d]: got %h pc %h cnt %0d, expected %h pc %h cnt %0d",
                         i, obs(), bus.redirect_pc, bus.stall_cnt, e_v, e_pc, e_cnt);
            end

            if (!rstn) begin
                in_drain = 0; refetch_due = 0; flush_left = 0; m_refetch = '0; stalls = '0;
            end else begin
                stalls = stalls + 32'(e_hif);
                if (bus.trap_redirect) begin
                    in_drain = 0; refetch_due = 0; flush_left = 0;
                end else if (refetch_due) begin
                    refetch_due = 0;
                end else if (flush_left > 0) begin
                    flush_left--;
                    if (flush_left == 0) refetch_due = 1;
                end else if (in_drain) begin
                    if (bus.sb_empty && !bus.lsu_busy && !bus.mdu_busy) begin
                        in_drain = 0; flush_left = ICF;
                    end
                end else if (acc_fence) begin
                    in_drain = 1; m_refetch = bus.fence_pc + 64'd4;
                end
            end
            next_cycle();
        end
        rstn = 1;
        idle();
    endtask

    initial begin
        idle();
        rstn = 0;
        next_cycle();
        test_reset();
        test_stall();
        test_branch(64'h8000_0100, 1'b0);
        test_branch({$urandom, $urandom}, 1'b1);
        test_fence(64'h8000_0040, 2);
        test_fence(64'hFFFF_FFFF_FFFF_FFFE, 1);
        test_trap_icflush();
        test_trap_branch();
        test_reset_midseq();
        test_random(600);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
